// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - round-robin write arbiter for one shared register
module shared_reg_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                   Clk,
  input  logic                   rst,
  input  logic [N-1:0]           req,
  input  logic [N-1:0]           wr_en,
  input  logic [N*W-1:0]         wr_data,
  output logic [N-1:0]           gnt,
  output logic [$clog2(N)-1:0]   owner,
  output logic [W-1:0]           q,
  output logic                   q_valid
);

  localparam int PW = $clog2(N);
  // hold_cnt must be at least one bit wide even when MAX_HOLD is 1
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [PW-1:0] LAST_IDX  = PW'(N - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [HW-1:0]   hold_cnt;

  logic            found;
  logic [PW-1:0]   win;
  logic [PW-1:0]   win_next;
  logic [N-1:0]    win_onehot;
  logic            own_req;
  logic            own_wr;
  logic [W-1:0]    own_data;
  logic            release_now;

  // Round-robin search starting at ptr. Because ptr sits one past the
  // current owner, the owner itself is visited last during re-arbitration.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  // Pointer advance and grant vector for the search winner
  always_comb begin
    win_next   = (win == LAST_IDX) ? '0 : win + 1'b1;
    win_onehot = '0;
    win_onehot[win] = 1'b1;
  end

  // Owner-side view of the request, strobe and data buses
  always_comb begin
    own_req     = req[owner];
    own_wr      = wr_en[owner];
    own_data    = wr_data[int'(owner)*W +: W];
    release_now = !own_req || (hold_cnt == HOLD_LAST);
  end

  // Arbitration FSM with registered grant/owner and the shared register
  always_ff @(posedge Clk) begin
    if (!rst) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      q        <= '0;
      q_valid  <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state    <= OWN;
            gnt      <= win_onehot;
            owner    <= win;
            ptr      <= win_next;
            hold_cnt <= '0;
          end
        end
        OWN: begin
          // the owner may write in every granted cycle, including the last
          if (own_wr) begin
            q       <= own_data;
            q_valid <= 1'b1;
          end
          if (release_now) begin
            if (found) begin
              gnt      <= win_onehot;
              owner    <= win;
              ptr      <= win_next;
              hold_cnt <= '0;
            end else begin
              state <= IDLE;
              gnt   <= '0;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb/tb_shared_reg_arbiter.sv - directed self-checking bench for shared_reg_arbiter
module tb_shared_reg_arbiter;

  logic        Clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  wr_en;
  logic [31:0] wr_data;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic [7:0]  q;
  logic        q_valid;

  int n_checks;
  int n_fail;

  shared_reg_arbiter #(.N(4), .W(8), .MAX_HOLD(4)) dut (
    .Clk     (Clk),
    .rst     (rst),
    .req     (req),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .gnt     (gnt),
    .owner   (owner),
    .q       (q),
    .q_valid (q_valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; wr_en = '0; wr_data = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 4'b1111; wr_en = 4'b1111; wr_data = 32'hDEAD_BEEF;
    tick();
    tick();
    n_checks++;
    if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
    n_checks++;
    if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q got=%h want=00", q); end
    n_checks++;
    if (q_valid !== 1'b0) begin n_fail++; $display("FAIL reset_qvalid got=%b want=0", q_valid); end
    n_checks++;
    if (owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner got=%0d want=0", owner); end
    req = '0; wr_en = '0; wr_data = '0; rst = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001; wr_en = 4'b0001; wr_data = 32'h0000_00A5;
    tick();
    n_checks++;
    if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt got=%b want=0001", gnt); end
    n_checks++;
    if (q_valid !== 1'b0) begin n_fail++; $display("FAIL single_qvalid_early got=%b want=0", q_valid); end
    tick();
    n_checks++;
    if (q !== 8'hA5) begin n_fail++; $display("FAIL single_q got=%h want=a5", q); end
    n_checks++;
    if (q_valid !== 1'b1) begin n_fail++; $display("FAIL single_qvalid got=%b want=1", q_valid); end
    req = '0; wr_en = '0;
    tick();
    n_checks++;
    if (gnt !== 4'b0000) begin n_fail++; $display("FAIL single_release got=%b want=0000", gnt); end
    n_checks++;
    if (q !== 8'hA5 || q_valid !== 1'b1) begin
      n_fail++; $display("FAIL single_hold got=%h/%b want=a5/1", q, q_valid);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g;
    do_reset();
    req = 4'b1111;
    tick();
    for (int g = 0; g < 5; g++) begin
      exp_g = 4'b0001 << (g % 4);
      for (int c = 0; c < 4; c++) begin
        n_checks++;
        if (gnt !== exp_g || owner !== 2'(g % 4)) begin
          n_fail++;
          $display("FAIL fair_g%0d_c%0d got=%b/%0d want=%b/%0d", g, c, gnt, owner, exp_g, g % 4);
        end
        tick();
      end
    end
    n_checks++;
    if (q_valid !== 1'b0) begin n_fail++; $display("FAIL fair_nowrite got=%b want=0", q_valid); end
    req = '0;
  endtask

  task automatic test_lone_hog();
    do_reset();
    req = 4'b0100; wr_en = 4'b0010; wr_data = 32'h0000_3C00;
    tick();
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (gnt !== 4'b0100) begin n_fail++; $display("FAIL hog_c%0d got=%b want=0100", c, gnt); end
      tick();
    end
    n_checks++;
    if (q !== 8'h00 || q_valid !== 1'b0) begin
      n_fail++; $display("FAIL hog_q got=%h/%b want=00/0", q, q_valid);
    end
    req = '0; wr_en = '0;
  endtask

  task automatic test_early_switch();
    do_reset();
    req = 4'b0001;
    tick();
    n_checks++;
    if (gnt !== 4'b0001) begin n_fail++; $display("FAIL switch_first got=%b want=0001", gnt); end
    req = 4'b1001;
    tick();
    n_checks++;
    if (gnt !== 4'b0001) begin n_fail++; $display("FAIL switch_keep got=%b want=0001", gnt); end
    req = 4'b1000; wr_en = 4'b0001; wr_data = 32'h0000_0011;
    tick();
    n_checks++;
    if (gnt !== 4'b1000 || owner !== 2'd3) begin
      n_fail++; $display("FAIL switch_gnt got=%b/%0d want=1000/3", gnt, owner);
    end
    n_checks++;
    if (q !== 8'h11) begin n_fail++; $display("FAIL switch_q got=%h want=11", q); end
    req = '0; wr_en = '0;
  endtask

  task automatic test_reset_mid_own();
    do_reset();
    req = 4'b0100;
    tick();
    wr_en = 4'b0100; wr_data = 32'h00AA_0000;
    tick();
    n_checks++;
    if (q !== 8'hAA) begin n_fail++; $display("FAIL midrst_pre got=%h want=aa", q); end
    rst = 1'b0; wr_data = 32'h00FF_0000;
    tick();
    n_checks++;
    if (q !== 8'h00 || gnt !== 4'b0000 || q_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_clear got=%h/%b/%b want=00/0000/0", q, gnt, q_valid);
    end
    rst = 1'b1; wr_en = '0; req = 4'b0110;
    tick();
    n_checks++;
    if (gnt !== 4'b0010 || owner !== 2'd1) begin
      n_fail++; $display("FAIL midrst_regrant got=%b/%0d want=0010/1", gnt, owner);
    end
    req = '0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0; req = '0; wr_en = '0; wr_data = '0;
    test_reset();
    test_single();
    test_fairness();
    test_lone_hog();
    test_early_switch();
    test_reset_mid_own();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
